// File: rtl/led_breathe_pwm.sv
// LED output stage: off / solid / triangle-breathing PWM / blink pass-through.
// All outputs registered; led follows inputs and counters with one cycle of latency.
module led_breathe_pwm #(
  parameter int N_LED        = 5,
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 763,
  parameter int HOLD_STEPS   = 64,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [1:0]          mode_i,
  input  logic                blink_in_i,
  output logic [N_LED-1:0]    led_o,
  output logic [PWM_BITS-1:0] level_o,
  output logic                period_tick_o
);

  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0]       HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_RISE, S_HOLD_HI, S_FALL, S_HOLD_LO
  } state_t;

  state_t              state_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] level_q;
  logic [SW-1:0]       step_cnt_q;
  logic [HW-1:0]       hold_cnt_q;
  logic [N_LED-1:0]    led_q;
  logic                period_tick_q;

  logic pwm_end, step_end, step_pulse, breathe, hold_done, lit_d;
  logic [N_LED-1:0] led_d;

  always_comb begin
    pwm_end    = en_i && (pwm_cnt_q == PWM_MAX);
    step_end   = (step_cnt_q == STEP_LAST);
    step_pulse = pwm_end && step_end;
    breathe    = (mode_i == 2'b10);
    hold_done  = (hold_cnt_q == HOLD_LAST);
    lit_d      = 1'b0;
    if (en_i) begin
      case (mode_i)
        2'b00:   lit_d = 1'b0;
        2'b01:   lit_d = 1'b1;
        2'b10:   lit_d = (pwm_cnt_q < level_q);
        2'b11:   lit_d = blink_in_i;
        default: lit_d = 1'b0;
      endcase
    end
    led_d = {N_LED{lit_d ^ ACTIVE_LOW}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      pwm_cnt_q     <= '0;
      level_q       <= '0;
      step_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      led_q         <= {N_LED{ACTIVE_LOW}};
      period_tick_q <= 1'b0;
    end else begin
      if (en_i) pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      period_tick_q <= pwm_end;
      led_q         <= led_d;
      if (pwm_end) step_cnt_q <= step_end ? '0 : step_cnt_q + SW'(1);

      // Leaving breathe mode wins over a coincident step and ignores en.
      if (!breathe) begin
        state_q    <= S_IDLE;
        level_q    <= '0;
        hold_cnt_q <= '0;
      end else if (en_i) begin
        case (state_q)
          S_IDLE: begin
            state_q    <= S_RISE;
            level_q    <= '0;
            hold_cnt_q <= '0;
            step_cnt_q <= '0;
          end
          S_RISE: if (step_pulse) begin
            if (level_q != PWM_MAX) level_q <= level_q + PWM_BITS'(1);
            if (level_q >= PWM_MAX - PWM_BITS'(1)) state_q <= S_HOLD_HI;
          end
          S_HOLD_HI: if (step_pulse) begin
            if (hold_done) begin
              state_q    <= S_FALL;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HW'(1);
            end
          end
          S_FALL: if (step_pulse) begin
            if (level_q != '0) level_q <= level_q - PWM_BITS'(1);
            if (level_q <= PWM_BITS'(1)) state_q <= S_HOLD_LO;
          end
          S_HOLD_LO: if (step_pulse) begin
            if (hold_done) begin
              state_q    <= S_RISE;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign led_o         = led_q;
  assign level_o       = level_q;
  assign period_tick_o = period_tick_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm with a small PWM (3 bits, 2 periods/step, hold 1).
module tb_led_breathe_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       blink = 1'b0;
  logic [4:0] led, led_al;
  logic [2:0] level, level_al;
  logic       tick, tick_al;

  int errs = 0;
  int checks = 0;

  // Expected-state tracking derived from the behavioural description.
  int   phase = 0;
  int   lvl_e = 0;
  bit   inb = 0;
  int   scnt = 0;
  int   sidx = 0;
  logic [4:0] led_e = '0;
  bit   tick_e = 0;
  int   tbl [16] = '{1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0};

  always #10 clk = ~clk;

  led_breathe_pwm #(.N_LED(5), .PWM_BITS(3), .STEP_PERIODS(2), .HOLD_STEPS(1), .ACTIVE_LOW(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .blink_in_i(blink),
    .led_o(led), .level_o(level), .period_tick_o(tick)
  );

  led_breathe_pwm #(.N_LED(5), .PWM_BITS(3), .STEP_PERIODS(2), .HOLD_STEPS(1), .ACTIVE_LOW(1'b1)) dut_al (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .blink_in_i(blink),
    .led_o(led_al), .level_o(level_al), .period_tick_o(tick_al)
  );

  task automatic tick_clk();
    bit r = rst;
    bit e = en;
    logic [1:0] m = mode;
    bit b = blink;
    bit lit = 0;
    bit pend = 0;
    if (!r && e) begin
      case (m)
        2'b01: lit = 1;
        2'b10: lit = (phase < lvl_e);
        2'b11: lit = b;
        default: lit = 0;
      endcase
    end
    led_e  = {5{lit}};
    tick_e = !r && e && (phase == 7);
    if (r) begin
      phase = 0; lvl_e = 0; inb = 0; scnt = 0;
    end else begin
      if (e) begin
        pend  = (phase == 7);
        phase = (phase + 1) % 8;
      end
      if (m != 2'b10) begin
        lvl_e = 0; inb = 0;
      end else if (e) begin
        if (!inb) begin
          inb = 1; scnt = 0; sidx = 0;
        end else if (pend) begin
          if (scnt == 1) begin
            scnt = 0; sidx++; lvl_e = tbl[(sidx - 1) % 16];
          end else begin
            scnt++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int nt = 0;
    rst = 1; en = 0; mode = 2'b00;
    tick_clk(); tick_clk();
    checks++; if (led !== 5'b00000) begin errs++; $display("FAIL reset_led: got %b want 00000", led); end
    checks++; if (led_al !== 5'b11111) begin errs++; $display("FAIL reset_led_al: got %b want 11111", led_al); end
    checks++; if (level !== 3'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (tick !== 1'b0) begin errs++; $display("FAIL reset_tick: got %b want 0", tick); end
    rst = 0; en = 1; mode = 2'b00;
    for (int i = 1; i <= 24; i++) begin
      tick_clk();
      if (tick === 1'b1) nt++;
      checks++; if (tick !== (i % 8 == 0)) begin errs++; $display("FAIL off_tick cyc %0d: got %b want %b", i, tick, (i % 8 == 0)); end
      checks++; if (led !== 5'b00000) begin errs++; $display("FAIL off_led cyc %0d: got %b want 00000", i, led); end
    end
    checks++; if (nt != 3) begin errs++; $display("FAIL off_tick_count: got %0d want 3", nt); end
  endtask

  task automatic test_solid();
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick_clk();
      checks++; if (led !== 5'b11111) begin errs++; $display("FAIL solid_led: got %b want 11111", led); end
      checks++; if (led_al !== 5'b00000) begin errs++; $display("FAIL solid_led_al: got %b want 00000", led_al); end
    end
  endtask

  task automatic test_breathe();
    int win = 0, lit3 = 0, maxl = 0;
    bit done3 = 0;
    mode = 2'b10;
    for (int i = 0; i < 320; i++) begin
      tick_clk();
      if (int'(level) > maxl) maxl = int'(level);
      checks++; if (level !== 3'(lvl_e)) begin errs++; $display("FAIL breathe_level cyc %0d: got %0d want %0d", i, level, lvl_e); end
      checks++; if (led !== led_e) begin errs++; $display("FAIL breathe_led cyc %0d: got %b want %b", i, led, led_e); end
      checks++; if (tick !== tick_e) begin errs++; $display("FAIL breathe_tick cyc %0d: got %b want %b", i, tick, tick_e); end
      checks++; if (led_al !== ~led) begin errs++; $display("FAIL breathe_led_al cyc %0d: got %b want %b", i, led_al, ~led); end
      if (win > 0) begin
        if (led === 5'b11111) lit3++;
        win--;
        if (win == 0) begin
          checks++; if (lit3 != 3) begin errs++; $display("FAIL duty_level3: got %0d want 3", lit3); end
        end
      end else if (!done3 && lvl_e == 3 && phase == 1) begin
        done3 = 1; win = 7; lit3 = (led === 5'b11111) ? 1 : 0;
      end
    end
    checks++; if (maxl != 7) begin errs++; $display("FAIL breathe_peak: got %0d want 7", maxl); end
    checks++; if (!done3) begin errs++; $display("FAIL duty_window: got 0 want 1"); end
  endtask

  task automatic test_blink();
    bit pb;
    mode = 2'b11; blink = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 0) blink = ~blink;
      pb = blink;
      tick_clk();
      checks++; if (led !== {5{pb}}) begin errs++; $display("FAIL blink_led cyc %0d: got %b want %b", i, led, {5{pb}}); end
    end
  endtask

  task automatic test_freeze();
    int n = 0;
    mode = 2'b10;
    while (lvl_e != 4 && n < 400) begin tick_clk(); n++; end
    checks++; if (n >= 400 || level !== 3'd4) begin errs++; $display("FAIL freeze_reach4: got %0d want 4", level); end
    en = 0;
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      checks++; if (led !== 5'b00000) begin errs++; $display("FAIL freeze_led cyc %0d: got %b want 00000", i, led); end
      checks++; if (level !== 3'd4) begin errs++; $display("FAIL freeze_level cyc %0d: got %0d want 4", i, level); end
      checks++; if (tick !== 1'b0) begin errs++; $display("FAIL freeze_tick cyc %0d: got %b want 0", i, tick); end
    end
    en = 1;
    for (int i = 0; i < 48; i++) begin
      tick_clk();
      checks++; if (level !== 3'(lvl_e)) begin errs++; $display("FAIL resume_level cyc %0d: got %0d want %0d", i, level, lvl_e); end
      checks++; if (led !== led_e) begin errs++; $display("FAIL resume_led cyc %0d: got %b want %b", i, led, led_e); end
      checks++; if (tick !== tick_e) begin errs++; $display("FAIL resume_tick cyc %0d: got %b want %b", i, tick, tick_e); end
    end
  endtask

  task automatic test_reset_mid_ramp();
    int n = 0;
    while (lvl_e != 5 && n < 400) begin tick_clk(); n++; end
    checks++; if (n >= 400 || level !== 3'd5) begin errs++; $display("FAIL midrst_reach5: got %0d want 5", level); end
    rst = 1;
    tick_clk();
    rst = 0;
    checks++; if (level !== 3'd0) begin errs++; $display("FAIL midrst_level: got %0d want 0", level); end
    checks++; if (led !== 5'b00000) begin errs++; $display("FAIL midrst_led: got %b want 00000", led); end
    checks++; if (led_al !== 5'b11111) begin errs++; $display("FAIL midrst_led_al: got %b want 11111", led_al); end
    checks++; if (tick !== 1'b0) begin errs++; $display("FAIL midrst_tick: got %b want 0", tick); end
    mode = 2'b01;
    tick_clk();
    checks++; if (led !== 5'b11111) begin errs++; $display("FAIL midrst_solid: got %b want 11111", led); end
    // Re-enter breathe, then leave it on the very edge that carries a step.
    mode = 2'b10;
    n = 0;
    while (!(inb && lvl_e >= 2 && phase == 7 && scnt == 1) && n < 400) begin tick_clk(); n++; end
    checks++; if (n >= 400) begin errs++; $display("FAIL step_edge_wait: got timeout want step edge"); end
    mode = 2'b01;
    tick_clk();
    checks++; if (level !== 3'd0) begin errs++; $display("FAIL step_vs_mode_level: got %0d want 0", level); end
    checks++; if (led !== 5'b11111) begin errs++; $display("FAIL step_vs_mode_led: got %b want 11111", led); end
    mode = 2'b10;
    for (int i = 0; i < 40; i++) begin
      tick_clk();
      checks++; if (level !== 3'(lvl_e)) begin errs++; $display("FAIL reenter_level cyc %0d: got %0d want %0d", i, level, lvl_e); end
    end
  endtask

  initial begin
    test_reset();
    test_solid();
    test_breathe();
    test_blink();
    test_freeze();
    test_reset_mid_ramp();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
